// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, bit-period table and
// default buffer depth. The transmitter uses the same baud encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int FIFO_DEPTH_DEFAULT = 32;

  // Wide enough for the slowest bit period (5208 clocks).
  localparam int BIT_CNT_W = 13;

  localparam logic [BIT_CNT_W-1:0] BIT_PERIOD_SEL0 = 13'd5208;
  localparam logic [BIT_CNT_W-1:0] BIT_PERIOD_SEL1 = 13'd2604;
  localparam logic [BIT_CNT_W-1:0] BIT_PERIOD_SEL2 = 13'd434;
  localparam logic [BIT_CNT_W-1:0] BIT_PERIOD_SEL3 = 13'd16;

  // Map a baud select code to its bit period in clocks.
  function automatic logic [BIT_CNT_W-1:0] bit_period(input logic [1:0] sel);
    logic [BIT_CNT_W-1:0] p;
    case (sel)
      2'd0:    p = BIT_PERIOD_SEL0;
      2'd1:    p = BIT_PERIOD_SEL1;
      2'd2:    p = BIT_PERIOD_SEL2;
      2'd3:    p = BIT_PERIOD_SEL3;
      default: p = BIT_PERIOD_SEL0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Receive byte buffer: first-word fall-through FIFO with fill level and
// a registered overrun pulse when a push hits a full buffer.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             overrun
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             overrun_r;

  logic empty_s;
  logic full_s;
  logic do_push_s;
  logic do_pop_s;
  logic overrun_s;

  // Qualify push/pop: pops on empty are ignored, a push into a full buffer
  // only succeeds when a pop frees a slot in the same cycle.
  always_comb begin
    empty_s   = (level_r == {LVL_W{1'b0}});
    full_s    = (level_r == LVL_W'(DEPTH));
    do_pop_s  = pop & ~empty_s;
    do_push_s = push & (~full_s | do_pop_s);
    overrun_s = push & full_s & ~do_pop_s;
  end

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, fill level and overrun pulse.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      level_r   <= {LVL_W{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_s;
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Head byte, forced to zero while empty so stale contents never show.
  always_comb begin
    if (empty_s) begin
      head = {WIDTH{1'b0}};
    end else begin
      head = mem_r[rd_ptr_r];
    end
    level   = level_r;
    empty   = empty_s;
    overrun = overrun_r;
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronizes the serial line, frames bytes with a
// four-state FSM sampling at bit centres, and buffers them in uart_fifo.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  read_enable,
  input  logic [5:0]            buffer_full_threshold,
  input  logic [1:0]            baudrate_select,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  buffer_empty,
  output logic                  buffer_full,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BIDX_W = $clog2(DATA_WIDTH);
  localparam logic [6:0] DEPTH7 = 7'(FIFO_DEPTH);

  logic [1:0]            rst_pipe_r;
  logic                  rst_n_int_s;
  logic                  rx_meta_r;
  logic                  rx_sync_r;
  logic                  rx_prev_r;

  uart_state_t           state_r, state_next;
  logic [BIT_CNT_W-1:0]  cnt_r, cnt_next;
  logic [BIT_CNT_W-1:0]  period_r, period_next;
  logic [BIDX_W-1:0]     bit_idx_r, bit_idx_next;
  logic [DATA_WIDTH-1:0] shift_r, shift_next;
  logic                  frame_error_r, frame_error_next;
  logic                  push_s;
  logic [BIT_CNT_W-1:0]  half_last_s;
  logic [BIT_CNT_W-1:0]  full_last_s;

  logic [LVL_W-1:0]      level_s;
  logic [6:0]            thr_ext_s;
  logic [6:0]            eff_thr_s;

  // Reset synchronizer: assert asynchronously, release on a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_pipe_r <= 2'b00;
    end else begin
      rst_pipe_r <= {rst_pipe_r[0], 1'b1};
    end
  end

  assign rst_n_int_s = rst_pipe_r[1];

  // Two-flop line synchronizer plus previous-value flop for edge detection.
  always_ff @(posedge clock or negedge rst_n_int_s) begin
    if (!rst_n_int_s) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= data_in;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // FSM state and frame datapath registers.
  always_ff @(posedge clock or negedge rst_n_int_s) begin
    if (!rst_n_int_s) begin
      state_r       <= IDLE;
      cnt_r         <= {BIT_CNT_W{1'b0}};
      period_r      <= BIT_PERIOD_SEL0;
      bit_idx_r     <= {BIDX_W{1'b0}};
      shift_r       <= {DATA_WIDTH{1'b0}};
      frame_error_r <= 1'b0;
    end else begin
      state_r       <= state_next;
      cnt_r         <= cnt_next;
      period_r      <= period_next;
      bit_idx_r     <= bit_idx_next;
      shift_r       <= shift_next;
      frame_error_r <= frame_error_next;
    end
  end

  // Next-state logic: half-period sample in START, full periods afterwards.
  always_comb begin
    state_next       = state_r;
    cnt_next         = cnt_r + 13'd1;
    period_next      = period_r;
    bit_idx_next     = bit_idx_r;
    shift_next       = shift_r;
    frame_error_next = 1'b0;
    push_s           = 1'b0;
    half_last_s      = {1'b0, period_r[BIT_CNT_W-1:1]} - 13'd1;
    full_last_s      = period_r - 13'd1;

    case (state_r)
      IDLE: begin
        cnt_next = {BIT_CNT_W{1'b0}};
        // A line held low after a break never re-triggers: needs high first.
        if (rx_prev_r && !rx_sync_r) begin
          state_next  = START;
          period_next = bit_period(baudrate_select);
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (cnt_r == half_last_s) begin
          cnt_next     = {BIT_CNT_W{1'b0}};
          bit_idx_next = {BIDX_W{1'b0}};
          if (!rx_sync_r) begin
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (cnt_r == full_last_s) begin
          cnt_next   = {BIT_CNT_W{1'b0}};
          shift_next = {rx_sync_r, shift_r[DATA_WIDTH-1:1]};
          if (bit_idx_r == BIDX_W'(DATA_WIDTH - 1)) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_r + BIDX_W'(1);
          end
        end else begin
          state_next = DATA;
        end
      end
      STOP: begin
        if (cnt_r == full_last_s) begin
          cnt_next   = {BIT_CNT_W{1'b0}};
          state_next = IDLE;
          if (rx_sync_r) begin
            push_s = 1'b1;
          end else begin
            frame_error_next = 1'b1;
          end
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = {BIT_CNT_W{1'b0}};
      end
    endcase
  end

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n_int_s),
    .push      (push_s),
    .push_data (shift_r),
    .pop       (read_enable),
    .head      (data_out),
    .level     (level_s),
    .empty     (buffer_empty),
    .overrun   (overrun)
  );

  // Effective threshold (0 or above depth means depth) and full flag.
  always_comb begin
    thr_ext_s = {1'b0, buffer_full_threshold};
    if ((buffer_full_threshold == 6'd0) || (thr_ext_s > DEPTH7)) begin
      eff_thr_s = DEPTH7;
    end else begin
      eff_thr_s = thr_ext_s;
    end
    buffer_full = (7'(level_s) >= eff_thr_s);
    frame_error = frame_error_r;
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected bytes,
// a monitor pops and compares whenever the buffer presents data.
module tb_uart_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b1;
  logic       read_enable = 1'b0;
  logic [5:0] buffer_full_threshold = 6'd32;
  logic [1:0] baudrate_select = 2'd3;
  logic [7:0] data_out;
  logic       buffer_empty;
  logic       buffer_full;
  logic       frame_error;
  logic       overrun;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] exp_q [$];
  bit         auto_read = 1'b0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;

  always #5 clock = ~clock;

  uart_receiver #(.FIFO_DEPTH(32), .DATA_WIDTH(8)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .data_in               (data_in),
    .read_enable           (read_enable),
    .buffer_full_threshold (buffer_full_threshold),
    .baudrate_select       (baudrate_select),
    .data_out              (data_out),
    .buffer_empty          (buffer_empty),
    .buffer_full           (buffer_full),
    .frame_error           (frame_error),
    .overrun               (overrun)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: counts pulse cycles and drains/compares presented bytes.
  initial begin
    forever begin
      @(negedge clock);
      if (frame_error === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      if (auto_read && buffer_empty === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", data_out);
        end else begin
          check("rx_byte", 32'(data_out), 32'(exp_q.pop_front()));
        end
        read_enable = 1'b1;
      end else begin
        read_enable = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive one frame; baud select is switched to new_sel after the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int period,
                            input logic [1:0] new_sel);
    data_in = 1'b0;
    idle(period);
    baudrate_select = new_sel;
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      idle(period);
    end
    data_in = stop;
    idle(period);
    data_in = 1'b1;
    idle(period);
  endtask

  task automatic send_good(input logic [7:0] b, input int period);
    exp_q.push_back(b);
    send_frame(b, 1'b1, period, baudrate_select);
  endtask

  task automatic wait_drain();
    int budget = 3000;
    while ((exp_q.size() != 0 || buffer_empty !== 1'b1) && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check("drain_timeout", 32'(budget > 0), 32'd1);
  endtask

  initial begin
    int f0;
    int o0;
    logic [7:0] rb;
    logic [7:0] pb;

    // Reset values while held and after release.
    reset = 1'b0;
    idle(4);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_empty", 32'(buffer_empty), 32'd1);
    check("rst_full", 32'(buffer_full), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b1;
    idle(6);
    check("post_rst_empty", 32'(buffer_empty), 32'd1);

    // Basic 0xA5 frame at select 3.
    auto_read = 1'b0;
    send_frame(8'hA5, 1'b1, 16, 2'd3);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_empty", 32'(buffer_empty), 32'd0);
    exp_q.push_back(8'hA5);
    auto_read = 1'b1;
    wait_drain();
    check("a5_read_empty", 32'(buffer_empty), 32'd1);

    // Short low glitch is rejected.
    f0 = ferr_cnt;
    data_in = 1'b0;
    idle(6);
    data_in = 1'b1;
    idle(40);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_empty", 32'(buffer_empty), 32'd1);
    send_good(8'h11, 16);
    wait_drain();

    // Bad stop bit.
    auto_read = 1'b0;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 16, 2'd3);
    check("badstop_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("badstop_empty", 32'(buffer_empty), 32'd1);

    // Break: one frame error, then quiet until the line returns high.
    f0 = ferr_cnt;
    data_in = 1'b0;
    idle(16 * 30);
    data_in = 1'b1;
    idle(32);
    check("break_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("break_empty", 32'(buffer_empty), 32'd1);
    auto_read = 1'b1;
    send_good(8'hC3, 16);
    wait_drain();

    // Baud select change mid-frame has no effect.
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 16, 2'd0);
    baudrate_select = 2'd3;
    wait_drain();

    // Threshold and overrun.
    auto_read = 1'b0;
    buffer_full_threshold = 6'd4;
    o0 = ovr_cnt;
    for (int b = 1; b <= 3; b++) send_frame(8'(b), 1'b1, 16, 2'd3);
    check("thr_below", 32'(buffer_full), 32'd0);
    send_frame(8'h04, 1'b1, 16, 2'd3);
    check("thr_reached", 32'(buffer_full), 32'd1);
    for (int b = 5; b <= 33; b++) send_frame(8'(b), 1'b1, 16, 2'd3);
    check("overrun_once", 32'(ovr_cnt - o0), 32'd1);
    check("full_head", 32'(data_out), 32'h01);
    buffer_full_threshold = 6'd40;
    #1;
    check("thr_over_depth", 32'(buffer_full), 32'd1);
    for (int b = 1; b <= 32; b++) exp_q.push_back(8'(b));
    auto_read = 1'b1;
    wait_drain();
    buffer_full_threshold = 6'd0;
    idle(2);
    check("thr_zero_empty", 32'(buffer_full), 32'd0);
    check("drain_empty", 32'(buffer_empty), 32'd1);

    // Random bytes at selects 2 and 3.
    buffer_full_threshold = 6'd32;
    baudrate_select = 2'd2;
    for (int i = 0; i < 2; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_good(rb, 434);
    end
    baudrate_select = 2'd3;
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_good(rb, 16);
    end
    wait_drain();

    // Reset during data bit 4 of a frame.
    auto_read = 1'b0;
    buffer_full_threshold = 6'd1;
    send_frame(8'h77, 1'b1, 16, 2'd3);
    check("pre_rst_data", 32'(data_out), 32'h77);
    check("pre_rst_full", 32'(buffer_full), 32'd1);
    pb = 8'hFF;
    data_in = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      data_in = pb[i];
      idle(16);
    end
    data_in = pb[4];
    idle(8);
    reset = 1'b0;
    #1;
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_empty", 32'(buffer_empty), 32'd1);
    check("midrst_full", 32'(buffer_full), 32'd0);
    data_in = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(200);
    check("midrst_no_partial", 32'(buffer_empty), 32'd1);
    buffer_full_threshold = 6'd32;
    auto_read = 1'b1;
    send_good(8'h5A, 16);
    wait_drain();
    idle(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
